// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-access pipeline stage with a blocking data-port handshake

package mem_access_pkg;
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    ctrl_t       ctrl;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rs2;
  } stage_regs;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
endpackage

module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  stage_regs   stage_in,
  input  logic        valid_in,
  input  logic        flush_in,
  output logic        stall_out,
  output stage_regs   stage_out,
  output logic        valid_out,
  output logic [31:0] mdr_out,
  output logic        misalign_out,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] stall_count
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      r_state, w_next;
  stage_regs   r_stage;
  logic        r_valid, r_misalign, r_flush_pend;
  logic [31:0] r_mdr, r_stall_count;
  logic        r_req_rd, r_req_wr;
  logic [31:0] r_req_addr, r_req_wdata;
  logic [3:0]  r_req_be;

  logic [1:0]  w_off;
  logic        w_is_mem, w_misaligned, w_mem_op, w_advance;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_rd, w_wr, w_stall;
  logic [31:0] w_addr, w_wd;
  logic [3:0]  w_bemask;

  // Byte-lane mask, shifted store data and alignment check from funct3 and address offset
  always_comb begin
    w_off        = stage_in.alu[1:0];
    w_is_mem     = stage_in.ctrl.mem_read | stage_in.ctrl.mem_write;
    w_misaligned = 1'b0;
    w_be         = 4'b0000;
    case (stage_in.funct3)
      F3_B, F3_BU: w_be = 4'b0001 << w_off;
      F3_H, F3_HU: begin
        w_be         = 4'b0011 << w_off;
        w_misaligned = w_off[0];
      end
      F3_W: begin
        w_be         = 4'b1111;
        w_misaligned = (w_off != 2'b00);
      end
      default: ;
    endcase
    if (!w_is_mem)                w_misaligned = 1'b0;
    if (!stage_in.ctrl.mem_write) w_be = 4'b0000;
    w_wdata  = stage_in.rs2 << {w_off, 3'b000};
    w_mem_op = valid_in & w_is_mem & ~w_misaligned;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next state: park in WAIT while a request is outstanding
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_mem_op && !dmem_resp) w_next = S_WAIT;
      S_WAIT: if (dmem_resp)              w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs: live request in IDLE, frozen copy in WAIT, silent under reset
  always_comb begin
    w_rd     = 1'b0;
    w_wr     = 1'b0;
    w_addr   = 32'h0;
    w_wd     = 32'h0;
    w_bemask = 4'b0000;
    w_stall  = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          w_rd     = w_mem_op & stage_in.ctrl.mem_read;
          w_wr     = w_mem_op & stage_in.ctrl.mem_write;
          w_addr   = {stage_in.alu[31:2], 2'b00};
          w_wd     = w_wdata;
          w_bemask = w_mem_op ? w_be : 4'b0000;
          w_stall  = w_mem_op & ~dmem_resp;
        end
        S_WAIT: begin
          w_rd     = r_req_rd;
          w_wr     = r_req_wr;
          w_addr   = r_req_addr;
          w_wd     = r_req_wdata;
          w_bemask = r_req_be;
          w_stall  = ~dmem_resp;
        end
        default: ;
      endcase
    end
  end

  assign w_advance = ~w_stall;

  // Snapshot the request issued from IDLE so WAIT replays it unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_rd    <= 1'b0;
      r_req_wr    <= 1'b0;
      r_req_addr  <= 32'h0;
      r_req_wdata <= 32'h0;
      r_req_be    <= 4'b0000;
    end else if (r_state == S_IDLE && w_mem_op) begin
      r_req_rd    <= stage_in.ctrl.mem_read;
      r_req_wr    <= stage_in.ctrl.mem_write;
      r_req_addr  <= {stage_in.alu[31:2], 2'b00};
      r_req_wdata <= w_wdata;
      r_req_be    <= w_be;
    end
  end

  // Pipeline register toward writeback, loaded whenever the stage is not stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage    <= '0;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
      r_mdr      <= 32'h0;
    end else if (w_advance) begin
      r_stage    <= stage_in;
      r_valid    <= valid_in & ~flush_in & ~r_flush_pend;
      r_misalign <= w_misaligned & valid_in;
      if (valid_in && stage_in.ctrl.mem_read && !w_misaligned) r_mdr <= dmem_rdata;
    end
  end

  // Remember a flush that lands while stalled; the transaction still completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_flush_pend <= 1'b0;
    else if (w_advance) r_flush_pend <= 1'b0;
    else if (flush_in)  r_flush_pend <= 1'b1;
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_stall_count <= 32'h0;
    else if (w_stall && r_stall_count != '1) r_stall_count <= r_stall_count + 32'd1;
  end

  assign stall_out        = w_stall;
  assign stage_out        = r_stage;
  assign valid_out        = r_valid;
  assign mdr_out          = r_mdr;
  assign misalign_out     = r_misalign;
  assign dmem_read        = w_rd;
  assign dmem_write       = w_wr;
  assign dmem_address     = w_addr;
  assign dmem_wdata       = w_wd;
  assign dmem_byte_enable = w_bemask;
  assign stall_count      = r_stall_count;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench for mem_access

module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  stage_regs   stage_in;
  logic        valid_in, flush_in;
  logic        stall_out;
  stage_regs   stage_out;
  logic        valid_out;
  logic [31:0] mdr_out;
  logic        misalign_out;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address, dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic [31:0] stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access dut (
    .clk(clk), .rst(rst), .stage_in(stage_in), .valid_in(valid_in), .flush_in(flush_in),
    .stall_out(stall_out), .stage_out(stage_out), .valid_out(valid_out), .mdr_out(mdr_out),
    .misalign_out(misalign_out), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic stage_regs mk(input logic rdm, input logic wrm, input logic [2:0] f3,
                                   input logic [31:0] alu, input logic [31:0] rs2);
    stage_regs s;
    s = '0;
    s.pc = 32'h0000_1000;
    s.ctrl.mem_read = rdm;
    s.ctrl.mem_write = wrm;
    s.ctrl.reg_write = rdm | ~wrm;
    s.funct3 = f3;
    s.rd = 5'd3;
    s.alu = alu;
    s.rs2 = rs2;
    return s;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; flush_in = 1'b0; dmem_resp = 1'b0; dmem_rdata = 32'h0;
    stage_in = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; #1;
    n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    n_tests++; if (stage_out !== '0) begin n_fail++; $display("FAIL reset_stage: got %h want 0", stage_out); end
    n_tests++; if (mdr_out !== 32'h0) begin n_fail++; $display("FAIL reset_mdr: got %h want 0", mdr_out); end
    n_tests++; if (misalign_out !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", misalign_out); end
    n_tests++; if (stall_count !== 32'h0) begin n_fail++; $display("FAIL reset_stall_count: got %0d want 0", stall_count); end
    n_tests++; if (stall_out !== 1'b0 || dmem_read !== 1'b0 || dmem_write !== 1'b0) begin
      n_fail++; $display("FAIL reset_strobes: got stall=%b rd=%b wr=%b want 0", stall_out, dmem_read, dmem_write); end
  endtask

  task automatic test_lw_wait();
    cyc();
    stage_in = mk(1'b1, 1'b0, F3_W, 32'h100, 32'h0); valid_in = 1'b1; #1;
    for (int c = 0; c < 3; c++) begin
      n_tests++; if (dmem_read !== 1'b1 || dmem_address !== 32'h100 || stall_out !== 1'b1) begin
        n_fail++; $display("FAIL lw_wait_c%0d: got rd=%b addr=%h stall=%b want 1/100/1", c, dmem_read, dmem_address, stall_out); end
      cyc();
    end
    dmem_resp = 1'b1; dmem_rdata = 32'hDEADBEEF; #1;
    n_tests++; if (stall_out !== 1'b0 || dmem_read !== 1'b1 || dmem_address !== 32'h100) begin
      n_fail++; $display("FAIL lw_resp: got stall=%b rd=%b addr=%h want 0/1/100", stall_out, dmem_read, dmem_address); end
    cyc();
    dmem_resp = 1'b0; valid_in = 1'b0; stage_in = '0;
    n_tests++; if (mdr_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_mdr: got %h want deadbeef", mdr_out); end
    n_tests++; if (valid_out !== 1'b1 || stage_out.alu !== 32'h100) begin
      n_fail++; $display("FAIL lw_out: got valid=%b alu=%h want 1/100", valid_out, stage_out.alu); end
    n_tests++; if (stall_count !== 32'd3) begin n_fail++; $display("FAIL lw_stall_count: got %0d want 3", stall_count); end
  endtask

  task automatic test_sb();
    stage_in = mk(1'b0, 1'b1, F3_B, 32'h203, 32'h0000_00AB); valid_in = 1'b1; dmem_resp = 1'b1; #1;
    n_tests++; if (dmem_write !== 1'b1 || dmem_read !== 1'b0 || dmem_address !== 32'h200) begin
      n_fail++; $display("FAIL sb_req: got wr=%b rd=%b addr=%h want 1/0/200", dmem_write, dmem_read, dmem_address); end
    n_tests++; if (dmem_byte_enable !== 4'b1000 || dmem_wdata !== 32'hAB00_0000) begin
      n_fail++; $display("FAIL sb_lane: got be=%b wdata=%h want 1000/ab000000", dmem_byte_enable, dmem_wdata); end
    n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL sb_stall: got %b want 0", stall_out); end
    cyc();
    n_tests++; if (valid_out !== 1'b1 || stage_out.alu !== 32'h203) begin
      n_fail++; $display("FAIL sb_out: got valid=%b alu=%h want 1/203", valid_out, stage_out.alu); end
  endtask

  task automatic test_sh_sw();
    stage_in = mk(1'b0, 1'b1, F3_H, 32'h102, 32'h0000_1234); valid_in = 1'b1; dmem_resp = 1'b1; #1;
    n_tests++; if (dmem_byte_enable !== 4'b1100 || dmem_wdata !== 32'h1234_0000 || dmem_write !== 1'b1) begin
      n_fail++; $display("FAIL sh_lane: got be=%b wdata=%h wr=%b want 1100/12340000/1", dmem_byte_enable, dmem_wdata, dmem_write); end
    cyc();
    n_tests++; if (misalign_out !== 1'b0) begin n_fail++; $display("FAIL sh_misalign: got %b want 0", misalign_out); end
    stage_in = mk(1'b0, 1'b1, F3_W, 32'h101, 32'h5555_5555); dmem_resp = 1'b0; #1;
    n_tests++; if (dmem_write !== 1'b0 || dmem_read !== 1'b0 || stall_out !== 1'b0) begin
      n_fail++; $display("FAIL sw_noreq: got wr=%b rd=%b stall=%b want 0/0/0", dmem_write, dmem_read, stall_out); end
    cyc();
    valid_in = 1'b0; stage_in = '0;
    n_tests++; if (misalign_out !== 1'b1 || valid_out !== 1'b1) begin
      n_fail++; $display("FAIL sw_misalign: got mis=%b valid=%b want 1/1", misalign_out, valid_out); end
  endtask

  task automatic test_flush_wait();
    stage_in = mk(1'b1, 1'b0, F3_W, 32'h40, 32'h0); valid_in = 1'b1; dmem_resp = 1'b0; #1;
    n_tests++; if (dmem_read !== 1'b1 || stall_out !== 1'b1) begin
      n_fail++; $display("FAIL flush_req: got rd=%b stall=%b want 1/1", dmem_read, stall_out); end
    cyc();
    flush_in = 1'b1; #1;
    n_tests++; if (stall_out !== 1'b1 || dmem_read !== 1'b1) begin
      n_fail++; $display("FAIL flush_hold1: got stall=%b rd=%b want 1/1", stall_out, dmem_read); end
    cyc();
    flush_in = 1'b0; #1;
    n_tests++; if (dmem_read !== 1'b1 || dmem_address !== 32'h40 || stall_out !== 1'b1) begin
      n_fail++; $display("FAIL flush_hold2: got rd=%b addr=%h stall=%b want 1/40/1", dmem_read, dmem_address, stall_out); end
    cyc();
    dmem_resp = 1'b1; dmem_rdata = 32'h0000_0011; #1;
    n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL flush_resp_stall: got %b want 0", stall_out); end
    cyc();
    dmem_resp = 1'b0; stage_in = mk(1'b0, 1'b0, 3'b000, 32'h5, 32'h0);
    n_tests++; if (valid_out !== 1'b0 || mdr_out !== 32'h11) begin
      n_fail++; $display("FAIL flush_out: got valid=%b mdr=%h want 0/11", valid_out, mdr_out); end
    cyc();
    n_tests++; if (valid_out !== 1'b1 || stage_out.alu !== 32'h5) begin
      n_fail++; $display("FAIL flush_clear: got valid=%b alu=%h want 1/5", valid_out, stage_out.alu); end
  endtask

  task automatic test_add_stream();
    for (int i = 0; i < 4; i++) begin
      stage_in = mk(1'b0, 1'b0, 3'b000, 32'h1000 + i, 32'h0); valid_in = 1'b1; #1;
      n_tests++; if (stall_out !== 1'b0 || dmem_read !== 1'b0) begin
        n_fail++; $display("FAIL add_stall_%0d: got stall=%b rd=%b want 0/0", i, stall_out, dmem_read); end
      cyc();
      n_tests++; if (valid_out !== 1'b1 || stage_out.alu !== 32'h1000 + i || mdr_out !== 32'h11) begin
        n_fail++; $display("FAIL add_out_%0d: got valid=%b alu=%h mdr=%h want 1/%h/11", i, valid_out, stage_out.alu, mdr_out, 32'h1000 + i); end
    end
    valid_in = 1'b0; stage_in = '0;
    n_tests++; if (stall_count !== 32'd6) begin n_fail++; $display("FAIL add_stall_count: got %0d want 6", stall_count); end
  endtask

  task automatic test_reset_mid_wait();
    stage_in = mk(1'b1, 1'b0, F3_W, 32'h80, 32'h0); valid_in = 1'b1; dmem_resp = 1'b0; #1;
    cyc();
    n_tests++; if (dmem_read !== 1'b1 || stall_out !== 1'b1) begin
      n_fail++; $display("FAIL rstw_wait: got rd=%b stall=%b want 1/1", dmem_read, stall_out); end
    rst = 1'b1; #1;
    n_tests++; if (dmem_read !== 1'b0 || stall_out !== 1'b0) begin
      n_fail++; $display("FAIL rstw_drop: got rd=%b stall=%b want 0/0", dmem_read, stall_out); end
    n_tests++; if (valid_out !== 1'b0 || mdr_out !== 32'h0 || stall_count !== 32'h0 || stage_out !== '0) begin
      n_fail++; $display("FAIL rstw_regs: got valid=%b mdr=%h cnt=%0d want 0/0/0", valid_out, mdr_out, stall_count); end
    valid_in = 1'b0; stage_in = '0;
    cyc();
    rst = 1'b0;
    cyc();
    dmem_resp = 1'b1; dmem_rdata = 32'h0000_0055; #1;
    n_tests++; if (dmem_read !== 1'b0 || stall_out !== 1'b0) begin
      n_fail++; $display("FAIL rstw_late_req: got rd=%b stall=%b want 0/0", dmem_read, stall_out); end
    cyc();
    dmem_resp = 1'b0;
    n_tests++; if (mdr_out !== 32'h0 || valid_out !== 1'b0 || stall_count !== 32'h0) begin
      n_fail++; $display("FAIL rstw_late_resp: got mdr=%h valid=%b cnt=%0d want 0/0/0", mdr_out, valid_out, stall_count); end
  endtask

  initial begin
    test_reset();
    test_lw_wait();
    test_sb();
    test_sh_sw();
    test_flush_wait();
    test_add_stream();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
